mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the RISC-TOY five-stage pipeline, directly downstream of the execute stage. It takes the execute result, the store data and the destination register for one instruction. For LD/LDR/ST/STR it runs a req/ready transaction on the data-memory port and freezes the upstream stages until that transaction completes. It registers the write-back bundle (rd, data, write enable) that feeds the register file and the forwarding network.

## Interface
Parameters:
- ADDR_W, 32, data-memory address width; the low ADDR_W bits of ex_result.
- DATA_W, 32, data word width.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset.
- ex_valid  in  1  execute stage presents a valid instruction.
- ex_opcode  in  5  5-bit opcode (LD=19, LDR=20, ST=21, STR=22; all others are non-memory).
- ex_result  in  32  ALU result, which is the effective address for memory ops.
- ex_store_data  in  DATA_W  RA value to be stored.
- ex_rd  in  5  destination register index.
- ex_wen  in  1  register-write request from decode.
- mem_stall  out  1  combinational; upstream stages hold all ex_* inputs while high.
- dmem_req  out  1  registered; memory request.
- dmem_we  out  1  registered; 1 = store, 0 = load.
- dmem_addr  out  ADDR_W  registered address.
- dmem_wdata  out  DATA_W  registered store data.
- dmem_ready  in  1  memory completes the access; sampled only while dmem_req=1.
- dmem_rdata  in  DATA_W  load data; valid in the cycle where dmem_ready=1.
- wb_valid  out  1  registered; the write-back bundle holds a retired instruction.
- wb_rd  out  5  registered destination.
- wb_data  out  DATA_W  registered write-back data.
- wb_wen  out  1  registered register-file write enable.

## Operation
- is_mem = ex_opcode in {LD, LDR, ST, STR}. is_load = LD or LDR.
- FSM has two states, IDLE and ACCESS. RST forces IDLE.
- **IDLE**
  - ex_valid=0: next cycle wb_valid=0 and wb_wen=0; wb_rd and wb_data hold.
  - ex_valid=1 and not is_mem: next cycle wb_valid=1, wb_rd=ex_rd, wb_data=ex_result, wb_wen=ex_wen.
  - ex_valid=1 and is_mem: capture ex_rd and is_load. Next cycle dmem_req=1, dmem_we=~is_load, dmem_addr=ex_result[ADDR_W-1:0], dmem_wdata=ex_store_data. Move to ACCESS. wb_valid=0 next cycle.
- **ACCESS**
  - ex_* inputs are ignored; upstream is holding the same instruction.
  - dmem_req, dmem_we, dmem_addr and dmem_wdata are held stable until dmem_ready=1.
  - dmem_ready=0: stay in ACCESS; wb_valid=0.
  - dmem_ready=1: next cycle dmem_req=0 and state returns to IDLE; wb_valid=1 and wb_rd=captured rd.
    - Load: wb_data=dmem_rdata, wb_wen=1.
    - Store: wb_wen=0 regardless of ex_wen; wb_data holds.
- mem_stall = (IDLE & ex_valid & is_mem) | (ACCESS & ~dmem_ready).
- Data passes through unmodified: no extension or masking.

## Timing
- Reset values: dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, wb_valid=0, wb_rd=0, wb_data=0, wb_wen=0. mem_stall=0 in the reset cycle regardless of inputs.
- Non-memory latency: 1 cycle from ex_valid to wb_valid.
- Memory latency: wb_valid asserts 2+N cycles after acceptance, where N is the number of dmem_ready=0 cycles while dmem_req=1. Minimum is 2 cycles, with ready in the first req cycle.
- After completion the upstream stage advances in the same cycle, because mem_stall drops once ready=1. The next instruction is therefore evaluated in IDLE on the following edge.
- Back-to-back memory ops: dmem_req deasserts for at least one cycle between transactions.
- dmem_ready while dmem_req=0 is ignored.
- RST asserted in ACCESS: IDLE and dmem_req=0 on that edge. The transaction is abandoned with no write-back; a late dmem_ready is ignored.
- X on ex_* while ex_valid=0 must not propagate to wb_valid or wb_wen.

## Structure
- Shared package risc_toy_pkg holds the 5-bit opcode constants (the same values the execute stage uses) and the mem_state_t enum {IDLE, ACCESS}.
- One sub-module is natural: mem_wb_reg, the write-back output register (valid/rd/data/wen with load and clear controls). The FSM and the memory-port registers stay in mem_stage.

## Test plan
- ADD result: ex_valid=1, opcode=4, ex_result=0x0000_0012, rd=3, wen=1 -> next cycle wb_valid=1, wb_rd=3, wb_data=0x12, wb_wen=1, mem_stall never high.
- LD with 2 wait states: opcode=19, ex_result=0x40, rd=5, memory returns 0xDEAD_BEEF on the third req cycle -> dmem_req high for 3 cycles, dmem_we=0, dmem_addr=0x40, mem_stall high for 3 cycles, then wb_data=0xDEAD_BEEF, wb_wen=1.
- ST with immediate ready: opcode=21, ex_result=0x80, store_data=0x1234 -> one req cycle with dmem_we=1, dmem_wdata=0x1234, then wb_valid=1, wb_wen=0 even with ex_wen=1.
- Back-to-back LDR then STR -> dmem_req low for ≥1 cycle between them, two wb_valid pulses, correct addresses and data in order.
- RST asserted during ACCESS with dmem_ready=0, then ready pulsed -> dmem_req=0 and all outputs at reset values after the edge, no wb_valid from the abandoned access.

Source files
------------

// File: rtl/risc_toy_pkg.sv
// Shared RISC-TOY definitions: opcode constants common to the execute and
// memory stages, plus the memory-stage FSM state type.
package risc_toy_pkg;

  localparam logic [4:0] OP_LD  = 5'd19;
  localparam logic [4:0] OP_LDR = 5'd20;
  localparam logic [4:0] OP_ST  = 5'd21;
  localparam logic [4:0] OP_STR = 5'd22;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

  function automatic logic op_is_mem(input logic [4:0] op);
    return (op == OP_LD) || (op == OP_LDR) || (op == OP_ST) || (op == OP_STR);
  endfunction

  function automatic logic op_is_load(input logic [4:0] op);
    return (op == OP_LD) || (op == OP_LDR);
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// Write-back bundle register. A load retires an instruction; without a load
// the bundle is invalidated but rd/data are kept for the forwarding network.
module mem_wb_reg #(
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ld,
  input  logic              ld_data,
  input  logic [4:0]        rd_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wen_in,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_wen
);

  always_ff @(posedge CLK) begin
    if (RST) begin
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      wb_wen   <= 1'b0;
    end else if (ld) begin
      wb_valid <= 1'b1;
      wb_rd    <= rd_in;
      wb_wen   <= wen_in;
      // stores retire without touching the data word
      if (ld_data) wb_data <= data_in;
    end else begin
      wb_valid <= 1'b0;
      wb_wen   <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// RISC-TOY memory-access stage: runs the data-memory req/ready handshake for
// loads/stores, stalls upstream meanwhile, and registers the write-back bundle.
//
// state  | meaning
// IDLE   | accepting instructions from execute; no memory request pending
// ACCESS | dmem_req held high until dmem_ready; upstream frozen
module mem_stage
  import risc_toy_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ex_valid,
  input  logic [4:0]        ex_opcode,
  input  logic [31:0]       ex_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [4:0]        ex_rd,
  input  logic              ex_wen,
  output logic              mem_stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_wen
);

  mem_state_t        state, next_state;
  logic [4:0]        rd_q;
  logic              is_load_q;
  logic              is_mem, is_load, accept_mem;
  logic              wb_ld, wb_ld_data, wb_wen_in;
  logic [4:0]        wb_rd_in;
  logic [DATA_W-1:0] wb_data_in;

  assign is_mem     = op_is_mem(ex_opcode);
  assign is_load    = op_is_load(ex_opcode);
  assign accept_mem = (state == IDLE) && ex_valid && is_mem;

  assign mem_stall = !RST && (accept_mem || ((state == ACCESS) && !dmem_ready));

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    wb_ld      = 1'b0;
    wb_ld_data = 1'b0;
    wb_rd_in   = ex_rd;
    wb_data_in = DATA_W'(ex_result);
    wb_wen_in  = ex_wen;
    case (state)
      IDLE: begin
        if (ex_valid) begin
          if (is_mem) begin
            next_state = ACCESS;
          end else begin
            wb_ld      = 1'b1;
            wb_ld_data = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (dmem_ready) begin
          next_state = IDLE;
          wb_ld      = 1'b1;
          wb_ld_data = is_load_q;
          wb_rd_in   = rd_q;
          wb_data_in = dmem_rdata;
          wb_wen_in  = is_load_q;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      rd_q       <= '0;
      is_load_q  <= 1'b0;
    end else if (accept_mem) begin
      dmem_req   <= 1'b1;
      dmem_we    <= !is_load;
      dmem_addr  <= ex_result[ADDR_W-1:0];
      dmem_wdata <= ex_store_data;
      rd_q       <= ex_rd;
      is_load_q  <= is_load;
    end else if ((state == ACCESS) && dmem_ready) begin
      dmem_req <= 1'b0;
    end
  end

  mem_wb_reg #(.DATA_W(DATA_W)) u_wb_reg (
    .CLK      (CLK),
    .RST      (RST),
    .ld       (wb_ld),
    .ld_data  (wb_ld_data),
    .rd_in    (wb_rd_in),
    .data_in  (wb_data_in),
    .wen_in   (wb_wen_in),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .wb_wen   (wb_wen)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: table of non-memory vectors plus
// hand-written load/store, back-to-back and reset-abort sequences.
module tb_mem_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ex_valid;
  logic [4:0]  ex_opcode;
  logic [31:0] ex_result;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_wen;
  logic        mem_stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_wen;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] exp_data;

  mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .ex_valid      (ex_valid),
    .ex_opcode     (ex_opcode),
    .ex_result     (ex_result),
    .ex_store_data (ex_store_data),
    .ex_rd         (ex_rd),
    .ex_wen        (ex_wen),
    .mem_stall     (mem_stall),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_ready    (dmem_ready),
    .dmem_rdata    (dmem_rdata),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .wb_wen        (wb_wen)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        valid;
    logic [4:0]  opcode;
    logic [31:0] result;
    logic [4:0]  rd;
    logic        wen;
    logic        ready;
    logic        exp_valid;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    logic        exp_wen;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_mem(input logic [4:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd,
                         input logic wen, input int waits, input logic [31:0] rdata);
    logic ld;
    ld = (op == 5'd19) || (op == 5'd20);
    ex_valid = 1'b1; ex_opcode = op; ex_result = addr;
    ex_store_data = wdata; ex_rd = rd; ex_wen = wen;
    dmem_ready = 1'b0;
    #1;
    check("req_gap", dmem_req, 1'b0);
    check("stall_accept", mem_stall, 1'b1);
    tick();
    for (int i = 0; i <= waits; i++) begin
      dmem_ready = (i == waits);
      dmem_rdata = (i == waits) ? rdata : (32'hBAD0_0000 + 32'(i));
      #1;
      check("req_high", dmem_req, 1'b1);
      check("req_we", dmem_we, !ld);
      check("req_addr", dmem_addr, addr);
      check("req_wdata", dmem_wdata, wdata);
      check("wb_idle_in_access", wb_valid, 1'b0);
      check("stall_access", mem_stall, (i < waits));
      tick();
    end
    dmem_ready = 1'b0;
    ex_valid = 1'b0;
    if (ld) exp_data = rdata;
    check("done_req", dmem_req, 1'b0);
    check("done_wb_valid", wb_valid, 1'b1);
    check("done_wb_rd", wb_rd, rd);
    check("done_wb_wen", wb_wen, ld);
    check("done_wb_data", wb_data, exp_data);
  endtask

  vec_t tbl[5];

  initial begin
    tbl[0] = '{1'b1, 5'd4,  32'h0000_0012, 5'd3,  1'b1, 1'b0, 1'b1, 5'd3,  32'h0000_0012, 1'b1};
    tbl[1] = '{1'b0, 5'd19, 32'hFFFF_0000, 5'd9,  1'b1, 1'b1, 1'b0, 5'd3,  32'h0000_0012, 1'b0};
    tbl[2] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd31, 1'b0, 1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF, 1'b0};
    tbl[3] = '{1'b1, 5'd23, 32'h0000_0055, 5'd1,  1'b1, 1'b0, 1'b1, 5'd1,  32'h0000_0055, 1'b1};
    tbl[4] = '{1'b1, 5'd18, 32'h0000_A5A5, 5'd0,  1'b1, 1'b1, 1'b1, 5'd0,  32'h0000_A5A5, 1'b1};

    RST = 1'b1; ex_valid = 1'b1; ex_opcode = 5'd19; ex_result = 32'h40;
    ex_store_data = '0; ex_rd = 5'd1; ex_wen = 1'b1;
    dmem_ready = 1'b0; dmem_rdata = '0;
    #1;
    check("stall_in_reset", mem_stall, 1'b0);
    tick(); tick();
    check("rst_req", dmem_req, 1'b0);
    check("rst_we", dmem_we, 1'b0);
    check("rst_addr", dmem_addr, 32'h0);
    check("rst_wdata", dmem_wdata, 32'h0);
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_wb_rd", wb_rd, 5'd0);
    check("rst_wb_data", wb_data, 32'h0);
    check("rst_wb_wen", wb_wen, 1'b0);
    ex_valid = 1'b0;
    RST = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      ex_valid = tbl[i].valid; ex_opcode = tbl[i].opcode; ex_result = tbl[i].result;
      ex_rd = tbl[i].rd; ex_wen = tbl[i].wen; dmem_ready = tbl[i].ready;
      #1;
      check("tbl_stall", mem_stall, 1'b0);
      tick();
      check("tbl_wb_valid", wb_valid, tbl[i].exp_valid);
      check("tbl_wb_rd", wb_rd, tbl[i].exp_rd);
      check("tbl_wb_data", wb_data, tbl[i].exp_data);
      check("tbl_wb_wen", wb_wen, tbl[i].exp_wen);
      check("tbl_req", dmem_req, 1'b0);
    end
    exp_data = tbl[4].exp_data;
    ex_valid = 1'b0; dmem_ready = 1'b0;
    tick();

    // LD with two wait states
    run_mem(5'd19, 32'h40, 32'h0, 5'd5, 1'b1, 2, 32'hDEAD_BEEF);
    tick();
    check("ld_pulse_end", wb_valid, 1'b0);

    // ST with immediate ready; ex_wen must not leak into wb_wen
    run_mem(5'd21, 32'h80, 32'h1234, 5'd7, 1'b1, 0, 32'h0BAD_0BAD);
    tick();
    check("st_pulse_end", wb_valid, 1'b0);

    // back-to-back LDR then STR
    run_mem(5'd20, 32'h100, 32'h0, 5'd9, 1'b1, 1, 32'hCAFE_0001);
    run_mem(5'd22, 32'h104, 32'h5555_AAAA, 5'd2, 1'b0, 0, 32'h0);
    tick();
    check("b2b_pulse_end", wb_valid, 1'b0);

    // reset while waiting for ready abandons the access
    ex_valid = 1'b1; ex_opcode = 5'd19; ex_result = 32'h200; ex_rd = 5'd4; ex_wen = 1'b1;
    dmem_ready = 1'b0;
    tick();
    check("abort_req_before", dmem_req, 1'b1);
    RST = 1'b1;
    #1;
    check("abort_stall_in_reset", mem_stall, 1'b0);
    tick();
    check("abort_req", dmem_req, 1'b0);
    check("abort_addr", dmem_addr, 32'h0);
    check("abort_wb_valid", wb_valid, 1'b0);
    check("abort_wb_data", wb_data, 32'h0);
    check("abort_wb_rd", wb_rd, 5'd0);
    RST = 1'b0; ex_valid = 1'b0; dmem_ready = 1'b1; dmem_rdata = 32'h1111_2222;
    tick();
    dmem_ready = 1'b0;
    check("late_ready_wb_valid", wb_valid, 1'b0);
    check("late_ready_wb_wen", wb_wen, 1'b0);
    check("late_ready_req", dmem_req, 1'b0);
    check("late_ready_stall", mem_stall, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
